haraka_s_absorb_padder: RTL and testbench
=========================================

Name: haraka_s_absorb_padder

Overview:
- Parametrised input stage for the Haraka-S sponge; replaces the fixed bit-serial `serial_in`/`process_input` front end with a configurable-width word stream.
- Packs input words into rate-sized blocks and applies Haraka-S (SHAKE-style) padding at message end.
- Hands each block to the permutation core over a valid/ready handshake.
- Sits between the testbench/host interface and the Haraka-S absorb/permute datapath.

Parameters:
- SERIAL_W, 8, input word width in bits; multiple of 8, divides RATE_BITS.
- RATE_BITS, 256, sponge rate (block size) in bits; multiple of 8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- serial_in  in  SERIAL_W  message word; byte 0 is bits [7:0].
- in_valid  in  1  serial_in carries a word.
- end_msg  in  1  message terminator; may coincide with in_valid.
- in_ready  out  1  word/end_msg accepted when high.
- blk_data  out  RATE_BITS  packed block; message byte k of the block is bits [8k+7:8k].
- blk_valid  out  1  blk_data valid.
- blk_last  out  1  block is the final padded block of the message.
- blk_ready  in  1  core accepts the block.
- busy  out  1  a message is partially absorbed (count!=0 or state!=FILL).

Behaviour:
- Constants: W = RATE_BITS/SERIAL_W words per block; NB = RATE_BITS/8 bytes per block.
- Word counter width is $clog2(W+1).
- States:
  - FILL: in_ready = 1.
  - EMIT: blk_valid = 1, in_ready = 0.
  - EMIT_PAD: full block pending; padding-only block queued.
- Reset (reset=0, async): state=FILL, count=0, blk_data=0, blk_valid=0, blk_last=0, busy=0. in_ready=1 after release.
- Reset mid-operation discards any partial block or pending block with no output.
- FILL, in_valid accepted: the word is written to slot `count`, then count++.
- FILL, count reaches W without end_msg: next cycle EMIT with blk_last=0, count=0.
- FILL, end_msg accepted:
  - If in_valid is also high, the word is written first, then end processing uses the updated count c.
  - Pad position p = c*SERIAL_W/8.
  - If p < NB: byte p = 0x1F, bytes p+1..NB-2 = 0, byte NB-1 |= 0x80 (gives 0x9F when p = NB-1). Go to EMIT with blk_last=1.
  - If p == NB (block exactly full): emit the data block with blk_last=0, then go to EMIT_PAD.
- EMIT_PAD: after that block transfers, present the padding-only block (byte0=0x1F, byte NB-1=0x80, rest 0, blk_last=1).
- Empty message (end_msg with c=0) yields a single padding-only block, blk_last=1.
- Latency: a block is registered at the edge accepting the completing word/end_msg; blk_valid is high the following cycle.
- Handshake:
  - Transfer occurs when blk_valid & blk_ready.
  - blk_data and blk_last are held stable while blk_valid=1 & blk_ready=0.
  - After transfer: EMIT returns to FILL (count=0, blk_last cleared); EMIT_PAD proceeds to EMIT with the padding block.
  - blk_valid may deassert in the cycle after transfer; no back-to-back blocks from the same message without a FILL cycle except the EMIT_PAD→EMIT sequence, which is back-to-back.
- in_valid/end_msg while in_ready=0 are ignored (source must hold).
- Unused block bytes are zero; no stale data from a previous message.

Optional Feature:
- Macro: HARAKAS_BLK_CNT_EN.
- Defined: adds output `blk_count` [15:0].
  - Increments on every block transfer.
  - Saturates at 0xFFFF.
  - Clears on reset and on the first word/end_msg accepted after a blk_last transfer.
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan (SERIAL_W=8, RATE_BITS=256):
1. Assert reset=0 mid-fill after 5 bytes, release → blk_valid=0, in_ready=1, busy=0. A following 1-byte message 0x00 gives byte0=0x00, byte1=0x1F, byte31=0x80.
2. Bytes 0x61,0x62,0x63 then end_msg → one block: bytes0..2=61 62 63, byte3=0x1F, bytes4..30=0, byte31=0x80, blk_last=1; blk_valid one cycle after end_msg accept.
3. end_msg only (empty message) → single block byte0=0x1F, byte31=0x80, others 0, blk_last=1.
4. 31 bytes 0x00 with end_msg on the 31st (simultaneous) → byte31=0x9F, blk_last=1.
5. 32 bytes 0xAA then end_msg → block1 all 0xAA, blk_last=0. Block2 follows: byte0=0x1F, byte31=0x80, blk_last=1. With macro, blk_count=2.
6. Hold blk_ready=0 for 5 cycles during EMIT while driving in_valid → blk_data stable, in_ready=0, no words absorbed. On blk_ready=1, transfer occurs and in_ready=1 next cycle.

Source files
------------

// File: rtl/haraka_s_absorb_padder.sv
// haraka_s_absorb_padder
//   Input stage for the Haraka-S sponge. Packs SERIAL_W-bit message words
//   into RATE_BITS-wide blocks, applies SHAKE-style padding (0x1F ... 0x80)
//   at message end, and hands blocks to the permutation core over a
//   valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   serial_in  message word, byte 0 in bits [7:0]
//   in_valid   serial_in carries a word
//   end_msg    message terminator, may coincide with in_valid
//   in_ready   word/end_msg accepted while high
//   blk_data   packed block, message byte k in bits [8k+7:8k]
//   blk_valid  blk_data valid
//   blk_last   final padded block of the message
//   blk_ready  core accepts the block
//   busy       a message is partially absorbed or a block is pending
//   blk_count  (HARAKAS_BLK_CNT_EN only) saturating transferred-block count
//
// Optional feature macro: HARAKAS_BLK_CNT_EN
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FILL     | accepting words into the block buffer
// EMIT     | block presented on blk_data, waiting for blk_ready
// EMIT_PAD | full data block presented; padding-only block follows it

module haraka_s_absorb_padder #(
  parameter int SERIAL_W  = 8,
  parameter int RATE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SERIAL_W-1:0]  serial_in,
  input  logic                 in_valid,
  input  logic                 end_msg,
  output logic                 in_ready,
  output logic [RATE_BITS-1:0] blk_data,
  output logic                 blk_valid,
  output logic                 blk_last,
  input  logic                 blk_ready,
  output logic                 busy
`ifdef HARAKAS_BLK_CNT_EN
  ,
  output logic [15:0]          blk_count
`endif
);

  localparam int W   = RATE_BITS / SERIAL_W;
  localparam int NB  = RATE_BITS / 8;
  localparam int BPW = SERIAL_W / 8;
  localparam int CW  = $clog2(W + 1);
  localparam int PW  = $clog2(NB + 1);

  localparam logic [RATE_BITS-1:0] PAD_ONLY =
    {8'h80, {(RATE_BITS-16){1'b0}}, 8'h1F};

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_EMIT     = 2'd1,
    S_EMIT_PAD = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [CW-1:0]        count, count_next;
  logic [RATE_BITS-1:0] data_next, data_word, data_pad;
  logic                 last_next;
  logic                 accept;
  logic [CW-1:0]        c_upd;
  logic [PW-1:0]        pad_pos;

  assign accept  = (state == S_FILL) && (in_valid || end_msg);
  assign c_upd   = count + CW'(in_valid);
  assign pad_pos = PW'(c_upd) * PW'(BPW);
  assign busy    = (count != '0) || (state != S_FILL);

  // Buffer with the incoming word merged into slot `count`.
  always_comb begin
    data_word = blk_data;
    for (int i = 0; i < W; i++) begin
      if (in_valid && (count == CW'(i)))
        data_word[i*SERIAL_W +: SERIAL_W] = serial_in;
    end
  end

  // Padded view of the merged buffer. Bytes past the message are already
  // zero because the buffer is cleared after every final transfer.
  always_comb begin
    data_pad = data_word;
    for (int k = 0; k < NB; k++) begin
      if (pad_pos == PW'(k))
        data_pad[k*8 +: 8] = 8'h1F;
    end
    data_pad[RATE_BITS-1 -: 8] = data_pad[RATE_BITS-1 -: 8] | 8'h80;
  end

  always_comb begin
    state_next = state;
    count_next = count;
    data_next  = blk_data;
    last_next  = blk_last;
    in_ready   = 1'b0;
    blk_valid  = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (accept) begin
          if (end_msg) begin
            count_next = '0;
            if (c_upd == CW'(W)) begin
              // Exactly full: send data first, padding block afterwards.
              data_next  = data_word;
              last_next  = 1'b0;
              state_next = S_EMIT_PAD;
            end else begin
              data_next  = data_pad;
              last_next  = 1'b1;
              state_next = S_EMIT;
            end
          end else if (c_upd == CW'(W)) begin
            data_next  = data_word;
            last_next  = 1'b0;
            count_next = '0;
            state_next = S_EMIT;
          end else begin
            data_next  = data_word;
            count_next = c_upd;
          end
        end
      end
      S_EMIT: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          data_next  = '0;
          last_next  = 1'b0;
          count_next = '0;
          state_next = S_FILL;
        end
      end
      S_EMIT_PAD: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          data_next  = PAD_ONLY;
          last_next  = 1'b1;
          state_next = S_EMIT;
        end
      end
      default: begin
        data_next  = '0;
        last_next  = 1'b0;
        count_next = '0;
        state_next = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FILL;
      count    <= '0;
      blk_data <= '0;
      blk_last <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      blk_data <= data_next;
      blk_last <= last_next;
    end
  end

`ifdef HARAKAS_BLK_CNT_EN
  // Count is kept after a message ends so the host can read it; it clears
  // when the next message starts.
  logic cnt_clr_pend;
  logic xfer;

  assign xfer = blk_valid && blk_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_count    <= '0;
      cnt_clr_pend <= 1'b0;
    end else if (accept && cnt_clr_pend) begin
      blk_count    <= '0;
      cnt_clr_pend <= 1'b0;
    end else if (xfer) begin
      if (blk_count != 16'hFFFF)
        blk_count <= blk_count + 16'd1;
      if (blk_last)
        cnt_clr_pend <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_haraka_s_absorb_padder.sv
module tb_haraka_s_absorb_padder;

  localparam int NB = 32;
  localparam logic [255:0] PAD_ONLY = {8'h80, {30{8'h00}}, 8'h1F};

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   serial_in;
  logic         in_valid, end_msg, in_ready;
  logic [255:0] blk_data;
  logic         blk_valid, blk_last, blk_ready, busy;
`ifdef HARAKAS_BLK_CNT_EN
  logic [15:0]  blk_count;
`endif

  haraka_s_absorb_padder #(.SERIAL_W(8), .RATE_BITS(256)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .in_valid(in_valid),
    .end_msg(end_msg), .in_ready(in_ready), .blk_data(blk_data),
    .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
    .busy(busy)
`ifdef HARAKAS_BLK_CNT_EN
    , .blk_count(blk_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rdy = 1'b0;

  logic [7:0]   msg_q[$];
  logic [255:0] got_data[$];
  bit           got_last[$];
  logic [255:0] exp_data[$];
  bit           exp_last[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, got timeout expected event", name);
  endtask

  // Collects transfers and checks hold stability during backpressure.
  bit           stall_prev = 1'b0;
  logic [255:0] prev_d;
  bit           prev_l;
  initial forever begin
    @(negedge clk);
    if (!reset) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        check("stall_valid", blk_valid, 1);
        check("stall_data", blk_data, prev_d);
        check("stall_last", blk_last, prev_l);
      end
      if (blk_valid && blk_ready) begin
        got_data.push_back(blk_data);
        got_last.push_back(blk_last);
      end
      stall_prev = blk_valid && !blk_ready;
      prev_d = blk_data;
      prev_l = blk_last;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) blk_ready = 1'($urandom_range(0, 1));
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    end_msg  = 1'b0;
  endtask

  task automatic send_msg(input bit merge, input bit gaps);
    int len = msg_q.size();
    for (int i = 0; i < len; i++) begin
      serial_in = msg_q[i];
      in_valid  = 1'b1;
      end_msg   = merge && (i == len - 1);
      wait_accept();
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
    if (!merge || len == 0) begin
      end_msg = 1'b1;
      wait_accept();
    end
  endtask

  task automatic wait_blocks(input int n);
    int k = 0;
    while (got_data.size() < n && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (got_data.size() < n) fail_now("block_timeout");
    repeat (3) begin @(posedge clk); #1; end
    check("block_count", got_data.size(), n);
  endtask

  // Reference: whole-message padding, then split into rate-sized blocks.
  task automatic model_expect();
    int len = msg_q.size();
    int padlen = (len / NB + 1) * NB;
    logic [255:0] blk = '0;
    logic [7:0] b;
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < padlen; i++) begin
      b = (i < len) ? msg_q[i] : 8'h00;
      if (i == len) b = 8'h1F;
      if (i == padlen - 1) b = b | 8'h80;
      blk[8*(i%NB) +: 8] = b;
      if (i % NB == NB - 1) begin
        exp_data.push_back(blk);
        exp_last.push_back(i == padlen - 1);
        blk = '0;
      end
    end
  endtask

  typedef struct {
    int           len;
    logic [7:0]   val;
    bit           incr;
    bit           merge;
    int           nblk;
    logic [255:0] exp0;
    bit           last0;
    logic [255:0] exp1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [255:0] abc_blk;
    vecs[0] = '{1,  8'h00, 0, 0, 1, {8'h80, {29{8'h00}}, 8'h1F, 8'h00}, 1, '0};
    vecs[1] = '{3,  8'h61, 1, 0, 1, {8'h80, {27{8'h00}}, 8'h1F, 8'h63, 8'h62, 8'h61}, 1, '0};
    vecs[2] = '{0,  8'h00, 0, 0, 1, PAD_ONLY, 1, '0};
    vecs[3] = '{31, 8'h00, 0, 1, 1, {8'h9F, {31{8'h00}}}, 1, '0};
    vecs[4] = '{32, 8'hAA, 0, 0, 2, {32{8'hAA}}, 0, PAD_ONLY};
    vecs[5] = '{32, 8'h10, 1, 1, 2, {8'h2F,8'h2E,8'h2D,8'h2C,8'h2B,8'h2A,8'h29,8'h28,
                                     8'h27,8'h26,8'h25,8'h24,8'h23,8'h22,8'h21,8'h20,
                                     8'h1F,8'h1E,8'h1D,8'h1C,8'h1B,8'h1A,8'h19,8'h18,
                                     8'h17,8'h16,8'h15,8'h14,8'h13,8'h12,8'h11,8'h10}, 0, PAD_ONLY};
    abc_blk = vecs[1].exp0;

    reset = 1'b0; serial_in = '0; in_valid = 0; end_msg = 0; blk_ready = 1'b1;
    #2;
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_last", blk_last, 0);
    check("rst_blk_data", blk_data, '0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);

    // Reset mid-fill after 5 bytes
    msg_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin serial_in = msg_q[i]; in_valid = 1; wait_accept(); end
    check("midfill_busy", busy, 1);
    reset = 1'b0;
    #2;
    check("midrst_busy", busy, 0);
    check("midrst_valid", blk_valid, 0);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("midrel_in_ready", in_ready, 1);
    check("midrel_busy", busy, 0);
    check("midrel_valid", blk_valid, 0);
    @(posedge clk); #1;

    // Table-driven directed vectors
    foreach (vecs[v]) begin
      msg_q.delete();
      for (int i = 0; i < vecs[v].len; i++)
        msg_q.push_back(vecs[v].incr ? 8'(vecs[v].val + 8'(i)) : vecs[v].val);
      got_data.delete(); got_last.delete();
      send_msg(vecs[v].merge, 0);
      wait_blocks(vecs[v].nblk);
      if (got_data.size() >= 1) begin
        check($sformatf("vec%0d_blk0", v), got_data[0], vecs[v].exp0);
        check($sformatf("vec%0d_last0", v), got_last[0], vecs[v].last0);
      end
      if (vecs[v].nblk == 2 && got_data.size() >= 2) begin
        check($sformatf("vec%0d_blk1", v), got_data[1], vecs[v].exp1);
        check($sformatf("vec%0d_last1", v), got_last[1], 1);
`ifdef HARAKAS_BLK_CNT_EN
        check($sformatf("vec%0d_blk_count", v), blk_count, 16'd2);
`endif
      end
      check($sformatf("vec%0d_idle_busy", v), busy, 0);
    end

    // Latency and backpressure: "abc" with blk_ready held low
    got_data.delete(); got_last.delete();
    blk_ready = 1'b0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    for (int i = 0; i < 3; i++) begin serial_in = msg_q[i]; in_valid = 1; wait_accept(); end
    end_msg = 1'b1;
    @(negedge clk);
    check("pre_accept_valid", blk_valid, 0);
    @(posedge clk); #1;
    end_msg = 1'b0;
    check("latency_valid", blk_valid, 1);
    check("latency_last", blk_last, 1);
    in_valid = 1'b1; serial_in = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_blk", blk_data, abc_blk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    check("post_xfer_in_ready", in_ready, 1);
    check("post_xfer_valid", blk_valid, 0);
    check("post_xfer_busy", busy, 0);
    check("stall_xfer_count", got_data.size(), 1);
    if (got_data.size() >= 1) check("stall_xfer_blk", got_data[0], abc_blk);

    // Randomized messages against the reference model
    rand_rdy = 1'b1;
    for (int m = 0; m < 40; m++) begin
      int len = $urandom_range(0, 80);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      model_expect();
      got_data.delete(); got_last.delete();
      send_msg(1'($urandom_range(0, 1)), 1);
      wait_blocks(exp_data.size());
      for (int b = 0; b < exp_data.size() && b < got_data.size(); b++) begin
        check($sformatf("rnd%0d_blk%0d", m, b), got_data[b], exp_data[b]);
        check($sformatf("rnd%0d_last%0d", m, b), got_last[b], exp_last[b]);
      end
    end
    rand_rdy = 1'b0;
    blk_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
